// File: rtl/pkg_axi_stream.sv
// Shared AXI constants, read-engine FSM states and the burst sizing rule.
package pkg_axi_stream;

  localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B      = 3'b010;
  localparam logic [3:0] AXI_CACHE_NC_BUF = 4'b0011;
  localparam logic [2:0] AXI_PROT_DATA    = 3'b000;
  localparam int         AXI_4KB          = 4096;
  localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, FINISH} rd_state_e;

  // Largest burst that fits the beat cap, the remaining words and the current 4KB page.
  function automatic logic [8:0] calc_beats(input logic [11:0] offset,
                                            input logic [29:0] words,
                                            input logic [8:0]  max_burst);
    logic [12:0] room;
    logic [8:0]  beats;
    room  = (13'(AXI_4KB) - {1'b0, offset}) >> 2;
    beats = max_burst;
    if (words < {21'd0, beats}) beats = words[8:0];
    if (room < {4'd0, beats}) beats = room[8:0];
    return beats;
  endfunction

endpackage

// File: rtl/dma_read_engine.sv
// AXI4 read master: fetches a buffer in 4KB-safe INCR bursts and forwards it
// beat-for-beat onto a 32-bit AXI-Stream with no buffering.
module dma_read_engine
  import pkg_axi_stream::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [31:0]           i_total_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready
);

  localparam logic [8:0] MAX_BURST_W = 9'(MAX_BURST);

  rd_state_e state_reg, state_next;

  logic [ADDR_WIDTH-1:0] addr_reg, araddr_reg, next_addr, burst_addr;
  logic [29:0]           words_left_reg, words_dec, burst_words;
  logic [8:0]            beat_cnt_reg, beats_reg, burst_beats;
  logic [7:0]            arlen_reg;
  logic                  arvalid_reg, error_reg, rlast_seen_reg;
  logic                  misaligned, beat_fire, last_beat, err_now;

  assign misaligned  = (|i_base_addr[1:0]) | (|i_total_len[1:0]);
  assign beat_fire   = (state_reg == DATA) && m_axi_rvalid && m_axis_tready;
  assign last_beat   = beat_fire && (beat_cnt_reg == 9'd1);
  assign words_dec   = words_left_reg - 30'd1;
  assign next_addr   = addr_reg + ADDR_WIDTH'({beats_reg, 2'b00});
  // An early or missing rlast is only judged once the burst's final beat arrives.
  assign err_now     = error_reg
                     | (beat_fire && (m_axi_rresp != AXI_RESP_OKAY))
                     | (last_beat && (!m_axi_rlast || rlast_seen_reg));
  assign burst_addr  = (state_reg == IDLE) ? i_base_addr : next_addr;
  assign burst_words = (state_reg == IDLE) ? i_total_len[31:2] : words_dec;
  assign burst_beats = calc_beats(burst_addr[11:0], burst_words, MAX_BURST_W);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          if (misaligned || (i_total_len == 32'd0)) state_next = FINISH;
          else                                      state_next = ADDR;
        end
      end
      ADDR: begin
        if (arvalid_reg && m_axi_arready) state_next = DATA;
      end
      DATA: begin
        if (last_beat) begin
          if ((words_dec == 30'd0) || err_now) state_next = FINISH;
          else                                 state_next = ADDR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      araddr_reg     <= '0;
      arlen_reg      <= '0;
      arvalid_reg    <= 1'b0;
      words_left_reg <= '0;
      beat_cnt_reg   <= '0;
      beats_reg      <= '0;
      error_reg      <= 1'b0;
      rlast_seen_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            addr_reg       <= i_base_addr;
            words_left_reg <= i_total_len[31:2];
            error_reg      <= misaligned;
          end
        end
        ADDR: begin
          if (m_axi_arready) begin
            arvalid_reg    <= 1'b0;
            beat_cnt_reg   <= beats_reg;
            rlast_seen_reg <= 1'b0;
          end
        end
        DATA: begin
          if (beat_fire) begin
            beat_cnt_reg   <= beat_cnt_reg - 9'd1;
            words_left_reg <= words_dec;
            error_reg      <= err_now;
            if (m_axi_rlast) rlast_seen_reg <= 1'b1;
          end
        end
        default: ;
      endcase
      // The AR channel is loaded once per burst and then held until accepted.
      if ((state_next == ADDR) && (state_reg != ADDR)) begin
        addr_reg    <= burst_addr;
        araddr_reg  <= burst_addr;
        arlen_reg   <= 8'(burst_beats - 9'd1);
        beats_reg   <= burst_beats;
        arvalid_reg <= 1'b1;
      end
    end
  end

  assign o_busy        = (state_reg != IDLE);
  assign o_done        = (state_reg == FINISH);
  assign o_error       = error_reg;
  assign m_axi_araddr  = araddr_reg;
  assign m_axi_arlen   = arlen_reg;
  assign m_axi_arsize  = AXI_SIZE_4B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arcache = AXI_CACHE_NC_BUF;
  assign m_axi_arprot  = AXI_PROT_DATA;
  assign m_axi_arvalid = arvalid_reg;
  assign m_axi_rready  = (state_reg == DATA) && m_axis_tready;
  assign m_axis_tvalid = (state_reg == DATA) && m_axi_rvalid;
  assign m_axis_tdata  = m_axi_rdata;
  assign m_axis_tlast  = (state_reg == DATA) && m_axi_rvalid && (words_left_reg == 30'd1);

endmodule

// File: tb/tb_dma_read_engine.sv
// Bench for dma_read_engine: randomised AXI slave memory plus a burst/stream
// reference model computed directly from the transfer rules.
module tb_dma_read_engine;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXB = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_base_addr = '0;
  logic [31:0]   i_total_len = '0;
  logic          o_busy, o_done, o_error;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize, m_axi_arprot;
  logic [1:0]    m_axi_arburst;
  logic [3:0]    m_axi_arcache;
  logic          m_axi_arvalid;
  logic          m_axi_arready = 1'b0;
  logic [DW-1:0] m_axi_rdata = '0;
  logic [1:0]    m_axi_rresp = 2'b00;
  logic          m_axi_rlast = 1'b0;
  logic          m_axi_rvalid = 1'b0;
  logic          m_axi_rready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast;
  logic          m_axis_tready = 1'b0;

  int errors = 0;
  int checks = 0;

  dma_read_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_total_len(i_total_len), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory contents: every word address maps to a distinct value.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  // ---------------- AXI slave / stream sink ----------------
  int          t_p = 100, a_p = 100, r_p = 100;
  int          err_beat = -1;
  int          beat_idx = 0;
  int          proto_viol = 0;
  bit          arvalid_seen = 0;
  logic [31:0] pend_addr[$];
  int          pend_len[$];
  logic [31:0] ar_addr_log[$];
  int          ar_len_log[$];
  logic [31:0] s_data[$];
  bit          s_last[$];
  bit          r_active = 0, r_hold = 0;
  logic [31:0] r_addr = '0;
  int          r_left = 0;
  int          last_latency = 0;

  always begin
    @(posedge clk);
    if (rst) begin
      pend_addr.delete();
      pend_len.delete();
      r_active = 0;
      r_hold   = 0;
    end else begin
      if (m_axi_arvalid) arvalid_seen = 1;
      if (m_axi_arvalid && m_axi_arready) begin
        if (r_active || pend_addr.size() != 0) proto_viol++;
        pend_addr.push_back(m_axi_araddr);
        pend_len.push_back(int'(m_axi_arlen) + 1);
        ar_addr_log.push_back(m_axi_araddr);
        ar_len_log.push_back(int'(m_axi_arlen));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        s_data.push_back(m_axis_tdata);
        s_last.push_back(m_axis_tlast);
      end
      r_hold = m_axi_rvalid && !m_axi_rready;
      if (m_axi_rvalid && m_axi_rready) begin
        r_addr = r_addr + 32'd4;
        r_left--;
        beat_idx++;
        if (r_left == 0) r_active = 0;
      end
    end
    @(negedge clk);
    m_axi_arready = ($urandom_range(0, 99) < a_p);
    m_axis_tready = ($urandom_range(0, 99) < t_p);
    if (!r_active && pend_addr.size() != 0) begin
      r_addr   = pend_addr.pop_front();
      r_left   = pend_len.pop_front();
      r_active = 1;
    end
    if (rst)         m_axi_rvalid = 1'b0;
    else if (r_hold) m_axi_rvalid = 1'b1;
    else             m_axi_rvalid = r_active && ($urandom_range(0, 99) < r_p);
    m_axi_rdata = word_at(r_addr);
    m_axi_rlast = (r_left == 1);
    m_axi_rresp = (beat_idx == err_beat) ? 2'b10 : 2'b00;
  end

  task automatic clear_logs();
    ar_addr_log.delete();
    ar_len_log.delete();
    s_data.delete();
    s_last.delete();
    beat_idx     = 0;
    proto_viol   = 0;
    arvalid_seen = 0;
  endtask

  // One transfer: model the expected bursts/stream, run it, compare everything.
  task automatic do_transfer(input string tag, input logic [31:0] base, input logic [31:0] len,
                             input int tp, input int ap, input int rp, input int eb, input bit spam);
    logic [31:0] ea[$];
    int          el[$];
    logic [31:0] a;
    int w, b, room, delivered, last_idx, cyc, nmis, nlast, pos;
    bit got, exp_err, stop;

    exp_err   = (base[1:0] != 2'b00) || (len[1:0] != 2'b00);
    stop      = exp_err;
    delivered = 0;
    a         = base;
    w         = int'(len >> 2);
    while (w > 0 && !stop) begin
      room = (4096 - int'(a % 4096)) / 4;
      b = MAXB;
      if (w < b) b = w;
      if (room < b) b = room;
      ea.push_back(a);
      el.push_back(b - 1);
      if (eb >= 0 && eb < delivered + b) begin
        stop    = 1;
        exp_err = 1;
      end
      delivered += b;
      a += 32'(4 * b);
      w -= b;
    end
    last_idx = (w == 0 && delivered > 0) ? delivered - 1 : -1;

    t_p = tp; a_p = ap; r_p = rp; err_beat = eb;
    clear_logs();
    @(negedge clk);
    i_start     = 1'b1;
    i_base_addr = base;
    i_total_len = len;
    cyc = 0;
    got = 0;
    while (!got && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (spam) begin
        i_base_addr = $urandom;
        i_total_len = $urandom;
      end else begin
        i_start = 1'b0;
      end
      if (o_done === 1'b1) got = 1;
    end
    i_start      = 1'b0;
    last_latency = cyc;

    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s done_timeout got=no_done_after_%0d_cycles exp=o_done", tag, cyc);
      return;
    end
    checks++;
    if (o_error !== exp_err) begin
      errors++;
      $display("FAIL %s error_flag got=%b exp=%b", tag, o_error, exp_err);
    end
    checks++;
    if (ar_addr_log.size() != ea.size()) begin
      errors++;
      $display("FAIL %s ar_count got=%0d exp=%0d", tag, ar_addr_log.size(), ea.size());
    end
    for (int i = 0; i < ea.size() && i < ar_addr_log.size(); i++) begin
      checks++;
      if (ar_addr_log[i] !== ea[i] || ar_len_log[i] !== el[i]) begin
        errors++;
        $display("FAIL %s ar[%0d] got=%h/%0d exp=%h/%0d", tag, i, ar_addr_log[i], ar_len_log[i], ea[i], el[i]);
      end
    end
    checks++;
    if (s_data.size() != delivered) begin
      errors++;
      $display("FAIL %s beat_count got=%0d exp=%0d", tag, s_data.size(), delivered);
    end
    nmis = 0;
    for (int i = 0; i < s_data.size(); i++)
      if (s_data[i] !== word_at(base + 32'(4 * i))) nmis++;
    checks++;
    if (nmis != 0) begin
      errors++;
      $display("FAIL %s data_order got=%0d_bad_beats exp=0", tag, nmis);
    end
    nlast = 0;
    pos   = -1;
    for (int i = 0; i < s_last.size(); i++)
      if (s_last[i]) begin
        nlast++;
        pos = i;
      end
    checks++;
    if (nlast != ((last_idx >= 0) ? 1 : 0) || pos != last_idx) begin
      errors++;
      $display("FAIL %s tlast got=count%0d_at%0d exp=at%0d", tag, nlast, pos, last_idx);
    end
    checks++;
    if (proto_viol != 0) begin
      errors++;
      $display("FAIL %s ar_overlap got=%0d exp=0", tag, proto_viol);
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done got=done%b_busy%b exp=done0_busy0", tag, o_done, o_busy);
    end
    $display("transfer %s base=%h len=%0d bursts=%0d beats=%0d err=%b", tag, base, len,
             ar_addr_log.size(), s_data.size(), o_error);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_busy, o_done, o_error, m_axi_arvalid, m_axi_rready, m_axis_tvalid} !== 6'b0) begin
      errors++;
      $display("FAIL reset ctrl got=%b exp=000000",
               {o_busy, o_done, o_error, m_axi_arvalid, m_axi_rready, m_axis_tvalid});
    end
    checks++;
    if (m_axi_araddr !== 32'h0 || m_axi_arlen !== 8'h0) begin
      errors++;
      $display("FAIL reset araddr_arlen got=%h/%h exp=0/0", m_axi_araddr, m_axi_arlen);
    end
    checks++;
    if ({m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arprot} !== {3'b010, 2'b01, 4'b0011, 3'b000}) begin
      errors++;
      $display("FAIL reset ar_consts got=%b exp=%b",
               {m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arprot}, {3'b010, 2'b01, 4'b0011, 3'b000});
    end
    rst = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_single_burst();
    do_transfer("single", 32'h1000_0000, 64, 100, 100, 100, -1, 0);
  endtask

  task automatic test_4kb_split();
    do_transfer("split4k", 32'h1000_0FF0, 32, 100, 100, 100, -1, 0);
    checks++;
    if (ar_addr_log.size() != 2 || ar_addr_log[1] !== 32'h1000_1000 || ar_len_log[1] !== 3) begin
      errors++;
      $display("FAIL split4k second_ar got=%0d_bursts exp=2_bursts_at_10001000_len3", ar_addr_log.size());
    end
  endtask

  task automatic test_zero_and_misaligned();
    do_transfer("zero_len", 32'h1000_0000, 0, 100, 100, 100, -1, 0);
    checks++;
    if (last_latency != 1 || arvalid_seen) begin
      errors++;
      $display("FAIL zero_len latency got=%0d_ar%b exp=1_ar0", last_latency, arvalid_seen);
    end
    do_transfer("bad_addr", 32'h1000_0002, 64, 100, 100, 100, -1, 0);
    checks++;
    if (arvalid_seen) begin
      errors++;
      $display("FAIL bad_addr arvalid got=1 exp=0");
    end
    do_transfer("bad_len", 32'h1000_0000, 6, 100, 100, 100, -1, 0);
    checks++;
    if (arvalid_seen) begin
      errors++;
      $display("FAIL bad_len arvalid got=1 exp=0");
    end
    do_transfer("clear_err", 32'h1000_0100, 16, 100, 100, 100, -1, 0);
  endtask

  task automatic test_resp_error();
    do_transfer("rresp_err", 32'h1000_0000, 128, 100, 100, 100, 2, 0);
  endtask

  task automatic test_random_stall();
    do_transfer("stall_1k", 32'h2000_0F00, 1024, 60, 50, 60, -1, 0);
  endtask

  task automatic test_back_to_back();
    do_transfer("start_held", 32'h1000_0FF8, 40, 70, 70, 70, -1, 1);
  endtask

  task automatic test_random_transfers();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] base, len;
      int eb;
      base = 32'h4000_0000 + 32'($urandom_range(0, 1023) * 4);
      len  = 32'($urandom_range(0, 80) * 4);
      eb   = (i % 3 == 0) ? $urandom_range(0, 20) : -1;
      do_transfer($sformatf("rand%0d", i), base, len, $urandom_range(30, 100),
                  $urandom_range(30, 100), $urandom_range(30, 100), eb, 0);
    end
  endtask

  task automatic test_reset_mid_data();
    int cyc;
    t_p = 100; a_p = 100; r_p = 100; err_beat = -1;
    clear_logs();
    @(negedge clk);
    i_start     = 1'b1;
    i_base_addr = 32'h3000_0000;
    i_total_len = 64;
    @(negedge clk);
    i_start = 1'b0;
    cyc = 0;
    while (s_data.size() < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (s_data.size() < 3) begin
      errors++;
      $display("FAIL rst_mid reach_data got=%0d_beats exp=3", s_data.size());
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({m_axi_arvalid, m_axi_rready, m_axis_tvalid, o_busy} !== 4'b0) begin
      errors++;
      $display("FAIL rst_mid outputs got=%b exp=0000", {m_axi_arvalid, m_axi_rready, m_axis_tvalid, o_busy});
    end
    rst = 1'b0;
    $display("reset during data checked");
    do_transfer("after_rst", 32'h3000_0040, 96, 80, 80, 80, -1, 0);
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_4kb_split();
    test_zero_and_misaligned();
    test_resp_error();
    test_random_stall();
    test_back_to_back();
    test_random_transfers();
    test_reset_mid_data();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
